// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared FSM state type, default geometry and word-count helper for the LUT writer.
package lut_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, ERROR} state_t;
  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 1;
  localparam int DEF_WORD_W   = 8;
  function automatic int nwords(input int in_bits, input int out_bits, input int word_w);
    return ((2 ** in_bits) * out_bits) / word_w;
  endfunction
endpackage

// File: rtl/lut_table_mem.sv
// lut_table_mem: distributed-RAM LUT, word-wide write, entry-wide registered lookup.
// The word-wide readback port exists only with LUT_READBACK_EN.
module lut_table_mem import lut_cfg_pkg::*; #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int IW       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [IW-1:0]       i_wr_idx,
  input  logic [WORD_W-1:0]   i_wr_data,
  input  logic                i_rd_en,
  input  logic [IN_BITS-1:0]  i_rd_addr,
  output logic [OUT_BITS-1:0] o_rd_data
`ifdef LUT_READBACK_EN
  ,
  input  logic [IW-1:0]       i_rb_idx,
  output logic [WORD_W-1:0]   o_rb_data
`endif
);
  localparam int EPW   = WORD_W / OUT_BITS;
  localparam int DEPTH = 2 ** IN_BITS;
  logic [OUT_BITS-1:0] r_mem [DEPTH];
  // Contents are deliberately not reset; tbl_valid masks stale data.
  always_ff @(posedge clk)
    if (i_wr_en)
      for (int k = 0; k < EPW; k++)
        r_mem[IN_BITS'(int'(i_wr_idx) * EPW + k)] <= i_wr_data[k*OUT_BITS +: OUT_BITS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
`ifdef LUT_READBACK_EN
  always_comb begin
    o_rb_data = '0;
    for (int k = 0; k < EPW; k++)
      o_rb_data[k*OUT_BITS +: OUT_BITS] = r_mem[IN_BITS'(int'(i_rb_idx) * EPW + k)];
  end
`endif
endmodule

// File: rtl/lut_table_writer.sv
// lut_table_writer: streams a packed table image into a LUT, validates its length, serves lookups.
// Define LUT_READBACK_EN to add the rb_req/rb_valid/rb_data image readback stream.
module lut_table_writer import lut_cfg_pkg::*; #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                tbl_valid,
  output logic                cfg_err,
  input  logic                eval_valid,
  input  logic [IN_BITS-1:0]  eval_addr,
  output logic                eval_out_valid,
  output logic [OUT_BITS-1:0] eval_out
`ifdef LUT_READBACK_EN
  ,
  input  logic                rb_req,
  output logic                rb_valid,
  output logic [WORD_W-1:0]   rb_data
`endif
);
  localparam int NW = nwords(IN_BITS, OUT_BITS, WORD_W);
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx;
  logic          r_drain, r_ready, r_eval_valid;
  logic          w_acc, w_at_end, w_discard, w_wr_en, w_rd_en;
  assign w_acc     = cfg_valid & cfg_ready;
  assign w_idx     = r_state == LOAD ? r_idx : '0;
  assign w_at_end  = w_idx == IW'(NW - 1);
  // r_drain marks an overrun image whose tail is swallowed up to its cfg_last.
  assign w_discard = r_state == ERROR && r_drain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_drain <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b1;
      if (w_acc) begin
        r_idx   <= w_at_end ? w_idx : w_idx + 1'b1;
        r_drain <= !cfg_last && (w_at_end || w_discard);
      end
    end
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc)
      w_state_nxt = w_discard ? ERROR :
                    cfg_last  ? (w_at_end ? ACTIVE : ERROR) :
                                (w_at_end ? ERROR : LOAD);
  end
  always_comb begin
    tbl_valid = r_state == ACTIVE;
    cfg_err   = r_state == ERROR;
    cfg_ready = r_ready;
    w_wr_en   = w_acc && !w_discard;
    w_rd_en   = eval_valid && tbl_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_eval_valid <= 1'b0;
    else r_eval_valid <= w_rd_en;
  assign eval_out_valid = r_eval_valid;
`ifdef LUT_READBACK_EN
  logic          r_rb_valid;
  logic [IW-1:0] r_rb_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rb_valid <= 1'b0;
      r_rb_idx   <= '0;
    end else if (!r_rb_valid) begin
      r_rb_valid <= rb_req && r_state == ACTIVE;
      r_rb_idx   <= '0;
    end else begin
      r_rb_valid <= r_rb_idx != IW'(NW - 1);
      r_rb_idx   <= r_rb_idx + 1'b1;
    end
  assign rb_valid = r_rb_valid;
`endif
  lut_table_mem #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_W(WORD_W), .IW(IW)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_data (cfg_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (eval_addr),
    .o_rd_data (eval_out)
`ifdef LUT_READBACK_EN
    ,
    .i_rb_idx  (r_rb_idx),
    .o_rb_data (rb_data)
`endif
  );
endmodule

// File: tb/tb_lut_table_writer.sv
// tb_lut_table_writer: directed vectors and multi-cycle sequences for lut_table_writer (default geometry).
module tb_lut_table_writer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cfg_valid = 1'b0, cfg_last = 1'b0, eval_valid = 1'b0;
  logic [7:0] cfg_data = '0;
  logic [5:0] eval_addr = '0;
  logic       cfg_ready, tbl_valid, cfg_err, eval_out_valid;
  logic [0:0] eval_out;
`ifdef LUT_READBACK_EN
  logic       rb_req = 1'b0, rb_valid;
  logic [7:0] rb_data;
`endif
  int n_cmp = 0, n_err = 0;
  typedef struct {logic ev; logic [5:0] a; logic v; logic o;} vec_t;
  vec_t vt[16];
  logic [7:0] img[8];

  always #5 clk = ~clk;

  lut_table_writer dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .tbl_valid(tbl_valid), .cfg_err(cfg_err),
    .eval_valid(eval_valid), .eval_addr(eval_addr), .eval_out_valid(eval_out_valid),
    .eval_out(eval_out)
`ifdef LUT_READBACK_EN
    , .rb_req(rb_req), .rb_valid(rb_valid), .rb_data(rb_data)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic word(input logic [7:0] d, input logic l);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = l;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic load(input logic [7:0] w[8]);
    for (int i = 0; i < 8; i++) word(w[i], i == 7);
  endtask

  task automatic look(input string nm, input logic [5:0] a, input logic v, input logic o);
    eval_valid = 1'b1; eval_addr = a;
    @(negedge clk);
    eval_valid = 1'b0;
    chk({nm, ".valid"}, eval_out_valid, v);
    if (v) chk({nm, ".out"}, eval_out, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 6'd0,  1'b1, 1'b1};
    vt[1]  = '{1'b0, 6'd1,  1'b0, 1'b1};
    vt[2]  = '{1'b1, 6'd1,  1'b1, 1'b0};
    vt[3]  = '{1'b1, 6'd7,  1'b1, 1'b1};
    vt[4]  = '{1'b1, 6'd8,  1'b1, 1'b1};
    vt[5]  = '{1'b1, 6'd9,  1'b1, 1'b0};
    vt[6]  = '{1'b1, 6'd16, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 6'd23, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 6'd28, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 6'd32, 1'b1, 1'b0};
    vt[10] = '{1'b1, 6'd41, 1'b1, 1'b1};
    vt[11] = '{1'b1, 6'd40, 1'b1, 1'b0};
    vt[12] = '{1'b1, 6'd52, 1'b1, 1'b1};
    vt[13] = '{1'b1, 6'd57, 1'b1, 1'b1};
    vt[14] = '{1'b1, 6'd63, 1'b1, 1'b0};
    vt[15] = '{1'b0, 6'd0,  1'b0, 1'b0};

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst.cfg_ready", cfg_ready, 0);
    chk("rst.tbl_valid", tbl_valid, 0);
    chk("rst.cfg_err", cfg_err, 0);
    chk("rst.eval_out_valid", eval_out_valid, 0);
    chk("rst.eval_out", eval_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready_after", cfg_ready, 1);
    look("idle_drop", 6'd0, 1'b0, 1'b0);

    // ramp image 00..07
    for (int i = 0; i < 7; i++) word(8'(i), 1'b0);
    chk("ramp.tbl_valid_before_last", tbl_valid, 0);
    word(8'h07, 1'b1);
    chk("ramp.tbl_valid", tbl_valid, 1);
    chk("ramp.cfg_err", cfg_err, 0);
    look("ramp.a8", 6'd8, 1'b1, 1'b1);
    look("ramp.a16", 6'd16, 1'b1, 1'b0);
    look("ramp.a17", 6'd17, 1'b1, 1'b1);

    // all 0xA5
    for (int i = 0; i < 8; i++) img[i] = 8'hA5;
    load(img);
    chk("a5.tbl_valid", tbl_valid, 1);
    look("a5.a0", 6'd0, 1'b1, 1'b1);
    look("a5.a1", 6'd1, 1'b1, 1'b0);

    // mixed image, table-driven lookups
    img = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'h10, 8'h02};
    load(img);
    for (int i = 0; i < 16; i++) begin
      eval_valid = vt[i].ev; eval_addr = vt[i].a;
      @(negedge clk);
      eval_valid = 1'b0;
      chk($sformatf("vec%0d.valid", i), eval_out_valid, vt[i].v);
      chk($sformatf("vec%0d.out", i), eval_out, vt[i].o);
    end

`ifdef LUT_READBACK_EN
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb%0d.valid", i), rb_valid, 1);
      chk($sformatf("rb%0d.data", i), rb_data, img[i]);
      @(negedge clk);
    end
    chk("rb.done", rb_valid, 0);
`endif

    // lookup coinciding with the first word of a reload sees the old table
    eval_valid = 1'b1; eval_addr = 6'd0;
    word(8'h00, 1'b0);
    eval_valid = 1'b0;
    chk("reload.old_valid", eval_out_valid, 1);
    chk("reload.old_out", eval_out, 1);
    chk("reload.tbl_valid", tbl_valid, 0);
    eval_valid = 1'b1; eval_addr = 6'd7;
    word(8'h00, 1'b0);
    eval_valid = 1'b0;
    chk("reload.drop_valid", eval_out_valid, 0);
    chk("reload.hold_out", eval_out, 1);
    for (int i = 0; i < 5; i++) word(8'h00, 1'b0);
    word(8'h00, 1'b1);
    chk("reload.tbl_valid_end", tbl_valid, 1);
    look("reload.a0", 6'd0, 1'b1, 1'b0);

    // early cfg_last on word 3
    word(8'hFF, 1'b0); word(8'hFF, 1'b0); word(8'hFF, 1'b1);
    chk("short.cfg_err", cfg_err, 1);
    chk("short.tbl_valid", tbl_valid, 0);
    look("short.lookup", 6'd0, 1'b0, 1'b0);

    // nine words, last on the ninth
    word(8'hFF, 1'b0);
    chk("long.err_cleared", cfg_err, 0);
    for (int i = 0; i < 7; i++) word(8'hFF, 1'b0);
    chk("long.err_after8", cfg_err, 1);
    chk("long.tbl_valid_after8", tbl_valid, 0);
    word(8'hFF, 1'b1);
    chk("long.err_after9", cfg_err, 1);
    for (int i = 0; i < 8; i++) img[i] = 8'h0F;
    word(img[0], 1'b0);
    chk("recover.err_cleared", cfg_err, 0);
    for (int i = 1; i < 8; i++) word(img[i], i == 7);
    chk("recover.tbl_valid", tbl_valid, 1);
    chk("recover.cfg_err", cfg_err, 0);
    look("recover.a3", 6'd3, 1'b1, 1'b1);
    look("recover.a4", 6'd4, 1'b1, 1'b0);

    // reset mid-load abandons the partial image
    for (int i = 0; i < 4; i++) word(8'hAA, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.tbl_valid", tbl_valid, 0);
    chk("midrst.cfg_err", cfg_err, 0);
    chk("midrst.eval_out", eval_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) img[i] = 8'(1 << i);
    load(img);
    chk("midrst.tbl_valid_new", tbl_valid, 1);
    chk("midrst.cfg_err_new", cfg_err, 0);
    look("midrst.a0", 6'd0, 1'b1, 1'b1);
    look("midrst.a1", 6'd1, 1'b1, 1'b0);
    look("midrst.a8", 6'd8, 1'b1, 1'b0);
    look("midrst.a9", 6'd9, 1'b1, 1'b1);
    look("midrst.a63", 6'd63, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
